// File: rtl/pipe_fwd_chain.sv
// Pipeline register chain between decode and writeback. Each stage holds a
// result payload, destination index, write-enable and late-result flag.
// NSRC operand lookups forward the youngest matching result, or raise a
// load-use hazard when that result is not available yet.
module pipe_fwd_chain #(
  parameter int unsigned STAGES = 3,
  parameter int unsigned DW     = 32,
  parameter int unsigned RW     = 5,
  parameter int unsigned NSRC   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [DW-1:0]        in_payload,
  input  logic [RW-1:0]        in_rd,
  input  logic                 in_we,
  input  logic                 in_late,
  output logic                 in_ready,
  input  logic                 hold,
  input  logic                 kill_in,
  input  logic [STAGES-1:0]    flush_mask,
  input  logic [NSRC*RW-1:0]   src_idx,
  input  logic [NSRC*DW-1:0]   src_rf,
  output logic [NSRC*DW-1:0]   src_data,
  output logic [NSRC-1:0]      hazard,
  input  logic [DW-1:0]        late_data,
  output logic                 out_valid,
  output logic [DW-1:0]        out_payload,
  output logic [RW-1:0]        out_rd,
  output logic                 out_we
);

  localparam int unsigned LAST = STAGES - 1;

  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] we_q, we_d;
  logic [STAGES-1:0] late_q, late_d;
  logic [DW-1:0]     payload_q [STAGES];
  logic [DW-1:0]     payload_d [STAGES];
  logic [RW-1:0]     rd_q [STAGES];
  logic [RW-1:0]     rd_d [STAGES];

  logic [DW-1:0]     fwd [NSRC];
  logic [NSRC-1:0]   haz;
  logic [RW-1:0]     idx;
  logic              found;
  logic              accept;

  // Operand lookup: scan from youngest to oldest, first match wins.
  // Entries being flushed this cycle are excluded from matching.
  always_comb begin
    haz   = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      idx    = src_idx[i*RW +: RW];
      fwd[i] = src_rf[i*DW +: DW];
      found  = 1'b0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (!found && valid_q[k] && we_q[k] && !flush_mask[k] &&
            (rd_q[k] == idx) && (idx != '0)) begin
          found = 1'b1;
          if (late_q[k]) begin
            if (k == LAST) fwd[i] = late_data;
            else           haz[i] = 1'b1;
          end else begin
            fwd[i] = payload_q[k];
          end
        end
      end
    end
  end

  for (genvar g = 0; g < NSRC; g++) begin : g_pack
    assign src_data[g*DW +: DW] = fwd[g];
  end

  assign hazard   = haz;
  assign in_ready = ~hold & ~(|haz);
  assign accept   = in_valid & in_ready & ~kill_in;

  // Next-state: advance the chain or hold it; flush clears valid in both cases.
  always_comb begin
    valid_d   = valid_q;
    we_d      = we_q;
    late_d    = late_q;
    payload_d = payload_q;
    rd_d      = rd_q;
    if (hold) begin
      valid_d = valid_q & ~flush_mask;
    end else begin
      for (int unsigned k = 1; k < STAGES; k++) begin
        valid_d[k]   = valid_q[k-1] & ~flush_mask[k-1];
        we_d[k]      = we_q[k-1];
        late_d[k]    = late_q[k-1];
        payload_d[k] = payload_q[k-1];
        rd_d[k]      = rd_q[k-1];
      end
      valid_d[0]   = accept;
      we_d[0]      = accept & in_we;
      late_d[0]    = accept & in_late;
      payload_d[0] = accept ? in_payload : '0;
      rd_d[0]      = accept ? in_rd : '0;
    end
  end

  // Stage registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      we_q    <= '0;
      late_q  <= '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        payload_q[k] <= '0;
        rd_q[k]      <= '0;
      end
    end else begin
      valid_q   <= valid_d;
      we_q      <= we_d;
      late_q    <= late_d;
      payload_q <= payload_d;
      rd_q      <= rd_d;
    end
  end

  assign out_valid   = valid_q[LAST];
  assign out_we      = valid_q[LAST] & we_q[LAST];
  assign out_rd      = rd_q[LAST];
  assign out_payload = (valid_q[LAST] & late_q[LAST]) ? late_data : payload_q[LAST];

endmodule

// File: tb/tb_pipe_fwd_chain.sv
// Directed bench for pipe_fwd_chain (STAGES=3, DW=32, RW=5, NSRC=2).
module tb_pipe_fwd_chain;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_payload;
  logic [4:0]  in_rd;
  logic        in_we;
  logic        in_late;
  logic        in_ready;
  logic        hold;
  logic        kill_in;
  logic [2:0]  flush_mask;
  logic [9:0]  src_idx;
  logic [63:0] src_rf;
  logic [63:0] src_data;
  logic [1:0]  hazard;
  logic [31:0] late_data;
  logic        out_valid;
  logic [31:0] out_payload;
  logic [4:0]  out_rd;
  logic        out_we;

  int n_cmp = 0;
  int n_bad = 0;

  pipe_fwd_chain #(.STAGES(3), .DW(32), .RW(5), .NSRC(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_payload(in_payload),
    .in_rd(in_rd), .in_we(in_we), .in_late(in_late), .in_ready(in_ready),
    .hold(hold), .kill_in(kill_in), .flush_mask(flush_mask),
    .src_idx(src_idx), .src_rf(src_rf), .src_data(src_data), .hazard(hazard),
    .late_data(late_data), .out_valid(out_valid), .out_payload(out_payload),
    .out_rd(out_rd), .out_we(out_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] p, input logic [4:0] r,
                       input logic we, input logic lt);
    in_valid = v; in_payload = p; in_rd = r; in_we = we; in_late = lt;
    #1;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #2;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if (out_we !== 1'b0) begin n_bad++; $display("FAIL rst_out_we got=%b exp=0", out_we); end
    n_cmp++; if (out_payload !== 32'h0) begin n_bad++; $display("FAIL rst_out_payload got=%h exp=0", out_payload); end
    n_cmp++; if (out_rd !== 5'd0) begin n_bad++; $display("FAIL rst_out_rd got=%h exp=0", out_rd); end
    n_cmp++; if (hazard !== 2'b00) begin n_bad++; $display("FAIL rst_hazard got=%b exp=00", hazard); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    hold = 1'b1; #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready_hold got=%b exp=0", in_ready); end
    hold = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back;
    drive(1'b1, 32'h11, 5'd3, 1'b1, 1'b0);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready got=%b exp=1", in_ready); end
    tick();
    drive(1'b1, 32'h22, 5'd4, 1'b1, 1'b0);
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_early_valid got=%b exp=0", out_valid); end
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_we !== 1'b1) begin n_bad++; $display("FAIL b2b_first_vld got=%b%b exp=11", out_valid, out_we); end
    n_cmp++; if (out_rd !== 5'd3 || out_payload !== 32'h11) begin n_bad++; $display("FAIL b2b_first got rd=%0d p=%h exp rd=3 p=11", out_rd, out_payload); end
    tick();
    n_cmp++; if (out_rd !== 5'd4 || out_payload !== 32'h22 || out_we !== 1'b1) begin n_bad++; $display("FAIL b2b_second got rd=%0d p=%h we=%b exp rd=4 p=22 we=1", out_rd, out_payload, out_we); end
    tick();
    n_cmp++; if (out_valid !== 1'b0 || out_we !== 1'b0) begin n_bad++; $display("FAIL b2b_drain got=%b%b exp=00", out_valid, out_we); end
  endtask

  task automatic test_forward_priority;
    drive(1'b1, 32'hBB, 5'd5, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'hAA, 5'd5, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    src_idx = {5'd5, 5'd5};
    src_rf  = {32'hCAFE, 32'hDEAD};
    #1;
    n_cmp++; if (src_data[31:0] !== 32'hAA) begin n_bad++; $display("FAIL fwd_young0 got=%h exp=aa", src_data[31:0]); end
    n_cmp++; if (src_data[63:32] !== 32'hAA) begin n_bad++; $display("FAIL fwd_young1 got=%h exp=aa", src_data[63:32]); end
    n_cmp++; if (hazard !== 2'b00) begin n_bad++; $display("FAIL fwd_hazard got=%b exp=00", hazard); end
    flush_mask = 3'b001; #1;
    n_cmp++; if (src_data[31:0] !== 32'hBB) begin n_bad++; $display("FAIL fwd_flush0 got=%h exp=bb", src_data[31:0]); end
    flush_mask = 3'b011; #1;
    n_cmp++; if (src_data[31:0] !== 32'hDEAD) begin n_bad++; $display("FAIL fwd_flush01 got=%h exp=dead", src_data[31:0]); end
    flush_mask = 3'b000;
    src_idx = '0;
    src_rf  = '0;
    idle(3);
  endtask

  task automatic test_load_use;
    drive(1'b1, 32'h999, 5'd7, 1'b1, 1'b1);
    tick();
    drive(1'b1, 32'h77, 5'd8, 1'b1, 1'b0);
    src_idx = {5'd7, 5'd0};
    src_rf  = {32'h5151, 32'h0};
    #1;
    n_cmp++; if (hazard !== 2'b10) begin n_bad++; $display("FAIL lu_hazard0 got=%b exp=10", hazard); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL lu_ready0 got=%b exp=0", in_ready); end
    tick();
    n_cmp++; if (hazard !== 2'b10 || in_ready !== 1'b0) begin n_bad++; $display("FAIL lu_stage1 got hz=%b rdy=%b exp hz=10 rdy=0", hazard, in_ready); end
    tick();
    late_data = 32'h1234; #1;
    n_cmp++; if (src_data[63:32] !== 32'h1234) begin n_bad++; $display("FAIL lu_late_fwd got=%h exp=1234", src_data[63:32]); end
    n_cmp++; if (hazard !== 2'b00 || in_ready !== 1'b1) begin n_bad++; $display("FAIL lu_release got hz=%b rdy=%b exp hz=00 rdy=1", hazard, in_ready); end
    n_cmp++; if (out_valid !== 1'b1 || out_rd !== 5'd7 || out_payload !== 32'h1234) begin n_bad++; $display("FAIL lu_out got v=%b rd=%0d p=%h exp v=1 rd=7 p=1234", out_valid, out_rd, out_payload); end
    tick();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    src_idx = '0;
    src_rf  = '0;
    late_data = '0;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL lu_bubble got=%b exp=0", out_valid); end
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_rd !== 5'd8 || out_payload !== 32'h77) begin n_bad++; $display("FAIL lu_next got v=%b rd=%0d p=%h exp v=1 rd=8 p=77", out_valid, out_rd, out_payload); end
    idle(2);
  endtask

  task automatic test_zero_index;
    drive(1'b1, 32'h55, 5'd0, 1'b1, 1'b1);
    tick();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    tick();
    src_idx = {5'd0, 5'd0};
    src_rf  = '0;
    #1;
    n_cmp++; if (src_data[31:0] !== 32'h0) begin n_bad++; $display("FAIL zero_data got=%h exp=0", src_data[31:0]); end
    n_cmp++; if (hazard !== 2'b00) begin n_bad++; $display("FAIL zero_hazard got=%b exp=00", hazard); end
    src_rf = {32'h0, 32'h66}; #1;
    n_cmp++; if (src_data[31:0] !== 32'h66) begin n_bad++; $display("FAIL zero_rf got=%h exp=66", src_data[31:0]); end
    src_rf = '0;
    idle(2);
  endtask

  task automatic test_kill;
    drive(1'b1, 32'h90, 5'd9, 1'b1, 1'b0);
    kill_in = 1'b1; #1;
    tick();
    kill_in = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    tick();
    tick();
    n_cmp++; if (out_valid !== 1'b0 || out_we !== 1'b0) begin n_bad++; $display("FAIL kill_out got=%b%b exp=00", out_valid, out_we); end
  endtask

  task automatic test_flush_hold;
    drive(1'b1, 32'h101, 5'd1, 1'b1, 1'b0); tick();
    drive(1'b1, 32'h102, 5'd2, 1'b1, 1'b0); tick();
    drive(1'b1, 32'h103, 5'd3, 1'b1, 1'b0); tick();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    n_cmp++; if (out_rd !== 5'd1 || out_valid !== 1'b1) begin n_bad++; $display("FAIL fh_full got rd=%0d v=%b exp rd=1 v=1", out_rd, out_valid); end
    hold = 1'b1; flush_mask = 3'b011;
    src_idx = {5'd0, 5'd3}; src_rf = {32'h0, 32'hF0};
    #1;
    n_cmp++; if (src_data[31:0] !== 32'hF0 || in_ready !== 1'b0) begin n_bad++; $display("FAIL fh_excl got=%h rdy=%b exp=f0 rdy=0", src_data[31:0], in_ready); end
    tick();
    flush_mask = 3'b000;
    src_idx = {5'd1, 5'd2}; #1;
    n_cmp++; if (out_valid !== 1'b1 || out_rd !== 5'd1 || out_payload !== 32'h101) begin n_bad++; $display("FAIL fh_keep got v=%b rd=%0d p=%h exp v=1 rd=1 p=101", out_valid, out_rd, out_payload); end
    n_cmp++; if (src_data[31:0] !== 32'hF0) begin n_bad++; $display("FAIL fh_s1_gone got=%h exp=f0", src_data[31:0]); end
    n_cmp++; if (src_data[63:32] !== 32'h101) begin n_bad++; $display("FAIL fh_s2_fwd got=%h exp=101", src_data[63:32]); end
    hold = 1'b0;
    src_idx = '0; src_rf = '0;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL fh_after got=%b exp=0", out_valid); end
    idle(2);
  endtask

  task automatic test_async_reset;
    drive(1'b1, 32'hA0, 5'd10, 1'b1, 1'b0); tick();
    drive(1'b1, 32'hB0, 5'd11, 1'b1, 1'b0); tick();
    drive(1'b1, 32'hC0, 5'd12, 1'b1, 1'b0); tick();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    n_cmp++; if (out_valid !== 1'b1 || out_payload !== 32'hA0) begin n_bad++; $display("FAIL ar_full got v=%b p=%h exp v=1 p=a0", out_valid, out_payload); end
    #1;
    rst = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || out_we !== 1'b0 || out_payload !== 32'h0) begin n_bad++; $display("FAIL ar_drop got v=%b we=%b p=%h exp 0 0 0", out_valid, out_we, out_payload); end
    src_idx = {5'd0, 5'd12}; src_rf = {32'h0, 32'h77}; #1;
    n_cmp++; if (src_data[31:0] !== 32'h77) begin n_bad++; $display("FAIL ar_nomatch got=%h exp=77", src_data[31:0]); end
    src_idx = '0; src_rf = '0;
    @(negedge clk);
    rst = 1'b1;
    tick();
    drive(1'b1, 32'hD0, 5'd13, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ar_early got=%b exp=0", out_valid); end
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_rd !== 5'd13 || out_payload !== 32'hD0) begin n_bad++; $display("FAIL ar_first got v=%b rd=%0d p=%h exp v=1 rd=13 p=d0", out_valid, out_rd, out_payload); end
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_payload = '0; in_rd = '0; in_we = 1'b0;
    in_late = 1'b0; hold = 1'b0; kill_in = 1'b0; flush_mask = '0;
    src_idx = '0; src_rf = '0; late_data = '0;
    test_reset();
    test_back_to_back();
    test_forward_priority();
    test_load_use();
    test_zero_index();
    test_kill();
    test_flush_hold();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_fwd_chain.md
Name: pipe_fwd_chain

Overview:
- Parametrised pipeline-register chain with built-in hazard detection and operand forwarding; replaces hand-instanced per-stage segment registers and separate forwarding muxes.
- Sits between decode and writeback. Carries STAGES entries, each holding payload, destination index, write-enable and a late-result flag.
- Serves NSRC operand lookups per cycle. Supports stall, per-stage flush and load-use bubble insertion.

Parameters:
STAGES, 3, number of register stages (>=2); stage 0 youngest, stage STAGES-1 oldest/retiring
DW, 32, payload/result width
RW, 5, register index width
NSRC, 2, number of operand lookup ports

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  new entry offered
in_payload  in  DW  result value of new entry (ALU result etc.)
in_rd  in  RW  destination index of new entry
in_we  in  1  new entry writes register file
in_late  in  1  result only available at oldest stage (load)
in_ready  out  1  entry accepted this cycle when in_valid&in_ready
hold  in  1  freeze all stages
kill_in  in  1  discard incoming entry
flush_mask  in  STAGES  bit k invalidates stage k at next edge
src_idx  in  NSRC*RW  operand indices of incoming entry, port i at [i*RW+:RW]
src_rf  in  NSRC*DW  register-file read values
src_data  out  NSRC*DW  forwarded operand values
hazard  out  NSRC  per-port load-use hazard
late_data  in  DW  external result for late entry at oldest stage (memory read data)
out_valid  out  1  oldest stage valid
out_payload  out  DW  oldest stage result (late_data if entry late)
out_rd  out  RW  oldest stage destination
out_we  out  1  out_valid & oldest we

Behaviour:
- Reset (rst=0, async): all stage valid/we/late cleared, payload/rd zeroed. out_valid=0, out_we=0, out_payload=0, out_rd=0. hazard=0. in_ready=1 unless hold=1.
- Priority at each edge: rst > flush_mask/kill_in > hold > advance.
- Advance (hold=0): stage k+1 <= stage k, valid cleared if flush_mask[k]. Stage 0 <= incoming entry, valid = in_valid & in_ready & ~kill_in. Otherwise stage 0 receives a bubble (valid=0, we=0).
- Oldest stage retires every non-held edge; there is no back-pressure at the output.
- Hold=1: all stages keep contents, except stages with flush_mask set, which clear valid.
- in_ready = ~hold & ~(|hazard). Combinational; latency 0 from src_idx to in_ready.
- Lookup, per port i, combinational:
  - match at stage k = valid & we & ~flush_mask[k] & rd==src_idx_i & src_idx_i!=0.
  - The youngest matching stage (lowest k) wins.
  - If no match: src_data_i = src_rf_i.
  - If the winner is late and k<STAGES-1: hazard_i=1, src_data_i=src_rf_i (don't-care, defined for verification).
  - If the winner is late and k=STAGES-1: src_data_i = late_data.
  - Otherwise: src_data_i = stage payload.
- Index 0 never matches and never raises hazard.
- Latency: an entry accepted at edge n appears at outputs after edge n+STAGES-1 when no hold occurs.
- Hazard with in_valid=1: entry not accepted, bubble inserted, older stages advance. Upstream must present the same entry until accepted.
- kill_in together with hazard: no entry is accepted, bubble inserted.
- Flush of a stage during hold: valid cleared immediately at that edge. Flushed entries are excluded from matching in the flush cycle.
- Reset mid-operation discards all entries; no partial retirement.

Test Plan:
- Back-to-back: accept rd=3 payload 0x11, then rd=4 payload 0x22, no hold -> out_rd=3/0x11 two edges after the first accept, rd=4 one cycle later; out_we=1 both.
- Forward priority: stage0 rd=5 payload 0xAA, stage1 rd=5 payload 0xBB, src_idx0=5 -> src_data0=0xAA, hazard=0.
- Load-use: stage0 rd=7 late=1, src_idx1=7, in_valid=1 -> hazard=2'b10, in_ready=0, next edge stage0 bubble. When the entry reaches stage2 with late_data=0x1234 -> src_data1=0x1234, in_ready=1.
- Zero index: stage1 rd=0 we=1 payload 0x55, src_idx0=0, src_rf0=0 -> src_data0=0, hazard=0.
- Flush under hold: hold=1, flush_mask=3'b011, stages full -> after edge stage0/1 invalid, stage2 unchanged, out_valid=1 retained.
- Async reset: assert rst=0 mid-cycle with stages full -> out_valid/out_we/out_payload drop to 0 before the next clk edge; after release, the first accepted entry retires after STAGES-1 edges.
